// File: rtl/rr_arb_4_pkg.sv
// Shared definitions for the four-requester round-robin arbiter:
// state encodings, sizing constants and the rotating-priority pick helper.
package rr_arb_4_pkg;

    // Number of requesting clients and width of the binary owner index
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    // Width of the grant-hold counter; it saturates at its all-ones value
    localparam int HOLD_W                = 8;
    localparam logic [HOLD_W-1:0] HOLD_SAT = '1;

    // Arbiter states: waiting for requests, or a client owns the resource
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // Round-robin selection: the first set request bit found when scanning
    // ptr, ptr+1, ptr+2, ptr+3 (wrapping mod 4). Returns 0 when nothing is
    // requested; callers only use the result when at least one bit is set.
    function automatic logic [ID_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] req_vec,
        input logic [ID_W-1:0]    ptr
    );
        logic [ID_W-1:0] idx;
        logic            found;
        rr_pick = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ptr + ID_W'(k);
            if (!found && req_vec[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/rr_arb_4_gnt_dec.sv
// 2-to-4 one-hot decoder with enable: turns the registered owner index into
// the grant vector, forcing all-zero when no grant is active.
module gnt_dec_2to4
    import rr_arb_4_pkg::*;
(
    input  logic [ID_W-1:0]    i_sel,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_onehot
);

    // One output bit per client, high only for the selected index when enabled
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_dec
            assign o_onehot[gi] = i_en && (i_sel == ID_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/rr_arb_4.sv
// Four-requester round-robin arbiter. A registered winner index is decoded
// into a one-hot grant that is held until the owner signals done, drops its
// request, or reaches the hold limit (HOLD_MAX cycles, 0 = no limit).
// Every output comes from registered state; req/done only affect next state.
module rr_arb_4
    import rr_arb_4_pkg::*;
#(
    parameter int HOLD_MAX = 16
)(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_valid,
    output logic               timeout
);

    // Counter value seen on the last permitted grant cycle. A grant starts
    // with the counter at 0, so releasing at HOLD_MAX-1 yields exactly
    // HOLD_MAX cycles of grant. Unused when the limit is disabled.
    localparam logic [HOLD_W-1:0] HOLD_LAST =
        (HOLD_MAX == 0) ? HOLD_SAT : HOLD_W'(HOLD_MAX - 1);

    // Registered state
    arb_state_t          r_state;
    logic [ID_W-1:0]     r_ptr;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [ID_W-1:0]     r_gnt_id;
    logic                r_timeout;

    // Next-state values and decoded conditions
    arb_state_t          w_state_next;
    logic [ID_W-1:0]     w_ptr_next;
    logic [HOLD_W-1:0]   w_hold_next;
    logic [ID_W-1:0]     w_gnt_id_next;
    logic                w_timeout_next;
    logic [ID_W-1:0]     w_pick;
    logic                w_owner_req;
    logic                w_limit_hit;
    logic                w_release;
    logic                w_gnt_active;

    // Rotating-priority winner among the current requests
    assign w_pick       = rr_pick(req, r_ptr);

    // Release conditions for the current owner
    assign w_owner_req  = req[r_gnt_id];
    assign w_limit_hit  = (HOLD_MAX != 0) && (r_hold_cnt == HOLD_LAST);
    assign w_release    = done || !w_owner_req || w_limit_hit;
    assign w_gnt_active = (r_state == ST_GRANT);

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
            r_gnt_id   <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ptr      <= w_ptr_next;
            r_hold_cnt <= w_hold_next;
            r_gnt_id   <= w_gnt_id_next;
            r_timeout  <= w_timeout_next;
        end
    end

    // Next-state logic: arbitrate in IDLE, count and watch for release in GRANT
    always_comb begin
        w_state_next   = r_state;
        w_ptr_next     = r_ptr;
        w_hold_next    = r_hold_cnt;
        w_gnt_id_next  = r_gnt_id;
        w_timeout_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_gnt_id_next = w_pick;
                    w_hold_next   = '0;
                    w_state_next  = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (r_hold_cnt != HOLD_SAT) begin
                    w_hold_next = r_hold_cnt + HOLD_W'(1);
                end
                if (w_release) begin
                    w_state_next   = ST_IDLE;
                    // Next arbitration starts just past the outgoing owner
                    w_ptr_next     = r_gnt_id + ID_W'(1);
                    // Only a pure hold-limit release is flagged as a timeout
                    w_timeout_next = w_limit_hit && !done && w_owner_req;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // One-hot grant decoded from the registered owner index
    gnt_dec_2to4 u_gnt_dec (
        .i_sel    (r_gnt_id),
        .i_en     (w_gnt_active),
        .o_onehot (gnt)
    );

    assign gnt_id    = r_gnt_id;
    assign gnt_valid = w_gnt_active;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_rr_arb_4.sv
// Directed testbench for rr_arb_4. Inputs change 1 time unit after each
// rising edge and outputs are sampled at the same point, so each step()
// reflects the state produced by exactly one clock edge.
module tb_rr_arb_4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       done;

    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    logic [3:0] gnt16;
    logic [1:0] gnt_id16;
    logic       gnt_valid16;
    logic       timeout16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Short hold limit instance used for all directed checks
    rr_arb_4 #(.HOLD_MAX(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    // Default hold limit instance sharing the same stimulus
    rr_arb_4 u_dut16 (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt16),
        .gnt_id    (gnt_id16),
        .gnt_valid (gnt_valid16),
        .timeout   (timeout16)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-18s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = 4'b0000;
        done = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_gnt;
        logic [1:0] exp_id;

        // ---- Reset values ----
        do_reset();
        chk("rst_gnt",     8'(gnt),       8'h0);
        chk("rst_valid",   8'(gnt_valid), 8'h0);
        chk("rst_id",      8'(gnt_id),    8'h0);
        chk("rst_timeout", 8'(timeout),   8'h0);

        // ---- Single client 2, done after 3 grant cycles, next ptr = 3 ----
        req = 4'b0100;
        step();
        chk("t1_gnt",   8'(gnt),       8'h4);
        chk("t1_id",    8'(gnt_id),    8'h2);
        chk("t1_valid", 8'(gnt_valid), 8'h1);
        step();
        step();
        done = 1'b1;
        step();
        chk("t1_drop",    8'(gnt),     8'h0);
        chk("t1_drop_to", 8'(timeout), 8'h0);
        done = 1'b0;
        req  = 4'b1111;
        step();
        chk("t1_ptr3_gnt", 8'(gnt),    8'h8);
        chk("t1_ptr3_id",  8'(gnt_id), 8'h3);

        // ---- All requesting, done on each 2nd grant cycle: order 0,1,2,3,0 ----
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_id  = 2'(k);
            exp_gnt = 4'b0001 << exp_id;
            step();
            chk("t2_gnt", 8'(gnt),    8'(exp_gnt));
            chk("t2_id",  8'(gnt_id), 8'(exp_id));
            step();
            chk("t2_hold", 8'(gnt), 8'(exp_gnt));
            done = 1'b1;
            step();
            chk("t2_bubble", 8'(gnt), 8'h0);
            done = 1'b0;
        end
        req = 4'b0000;
        step();

        // ---- Hold limit 4: exactly 4 cycles, timeout pulse, re-grant ----
        do_reset();
        req = 4'b0010;
        step();
        chk("t3_gnt_c1", 8'(gnt), 8'h2);
        for (int c = 2; c <= 4; c++) begin
            step();
            chk("t3_gnt_hold", 8'(gnt), 8'h2);
        end
        step();
        chk("t3_drop",     8'(gnt),       8'h0);
        chk("t3_timeout",  8'(timeout),   8'h1);
        chk("t3_valid",    8'(gnt_valid), 8'h0);
        chk("t3_dflt_gnt", 8'(gnt16),     8'h2);
        chk("t3_dflt_to",  8'(timeout16), 8'h0);
        step();
        chk("t3_regrant",  8'(gnt),     8'h2);
        chk("t3_to_clear", 8'(timeout), 8'h0);

        // ---- Hold limit 4 with done on the 4th cycle: no timeout ----
        do_reset();
        req = 4'b0010;
        step();
        step();
        step();
        step();
        chk("t4_gnt_c4", 8'(gnt), 8'h2);
        done = 1'b1;
        step();
        chk("t4_drop",    8'(gnt),     8'h0);
        chk("t4_timeout", 8'(timeout), 8'h0);
        done = 1'b0;
        req  = 4'b0000;
        step();

        // ---- Owner 3 drops its request, ptr wraps to 0 ----
        do_reset();
        req = 4'b1000;
        step();
        chk("t5_gnt3", 8'(gnt), 8'h8);
        req = 4'b1011;
        step();
        chk("t5_hold3", 8'(gnt), 8'h8);
        req = 4'b0011;
        step();
        chk("t5_drop",    8'(gnt),     8'h0);
        chk("t5_timeout", 8'(timeout), 8'h0);
        step();
        chk("t5_gnt0", 8'(gnt),    8'h1);
        chk("t5_id0",  8'(gnt_id), 8'h0);

        // ---- Reset during an active grant of client 2 ----
        do_reset();
        req = 4'b0100;
        step();
        chk("t6_gnt2", 8'(gnt), 8'h4);
        req = 4'b1111;
        rst = 1'b1;
        step();
        chk("t6_rst_gnt",   8'(gnt),       8'h0);
        chk("t6_rst_valid", 8'(gnt_valid), 8'h0);
        chk("t6_rst_to",    8'(timeout),   8'h0);
        chk("t6_rst_id",    8'(gnt_id),    8'h0);
        rst = 1'b0;
        step();
        chk("t6_gnt0", 8'(gnt),    8'h1);
        chk("t6_id0",  8'(gnt_id), 8'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
